out_mem_dram_writer: RTL and testbench

- Downstream of the output-memory write controller. When the controller pulses out_buf_ready, this block reads back the just-completed out_mem burst (7 rows for CONV, 1 word for FC) and streams it to the DRAM write port with valid/ready handshaking.
- Keeps a running DRAM write pointer across bursts and reports completion and overrun.

---
 rtl/out_mem_dram_writer.sv | 177 +++++++++++++++++
 tb/tb_out_mem_dram_writer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_mem_dram_writer.sv
// ---------------------------------------------------------------------------
// out_mem_dram_writer
//
// Reads back a completed out_mem burst (7 rows for CONV, 1 word for FC) and
// streams it to the DRAM write port with valid/ready handshaking. Keeps a
// running DRAM write pointer so consecutive bursts are packed contiguously.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   conv_or_fc        layer type (00 CONV, 01 FC), sampled with out_buf_ready
//   out_buf_ready     1-cycle pulse: an out_mem burst is ready to be written
//   dram_base_load    load the DRAM pointer from dram_base_addr (IDLE only)
//   dram_base_addr    new DRAM pointer value
//   out_mem_rd_addr   out_mem read address
//   en_out_mem_rd     out_mem read enable (data returns on the next cycle)
//   out_mem_dout      out_mem read data
//   dram_wr_valid     DRAM write request valid
//   dram_wr_addr      DRAM write address
//   dram_wr_data      DRAM write data
//   dram_wr_ready     DRAM accepts the request when valid && ready
//   busy              burst in progress
//   wb_done           1-cycle pulse after the last word of a burst is accepted
//   overrun_err       sticky: out_buf_ready arrived while busy
// ---------------------------------------------------------------------------
module out_mem_dram_writer #(
  parameter int DATA_W      = 32,
  parameter int DRAM_ADDR_W = 32,
  parameter int ADDR_STRIDE = 4,
  parameter int CONV_BURST  = 7,
  parameter int FC_BURST    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             conv_or_fc,
  input  logic                   out_buf_ready,
  input  logic                   dram_base_load,
  input  logic [DRAM_ADDR_W-1:0] dram_base_addr,
  output logic [12:0]            out_mem_rd_addr,
  output logic                   en_out_mem_rd,
  input  logic [DATA_W-1:0]      out_mem_dout,
  output logic                   dram_wr_valid,
  output logic [DRAM_ADDR_W-1:0] dram_wr_addr,
  output logic [DATA_W-1:0]      dram_wr_data,
  input  logic                   dram_wr_ready,
  output logic                   busy,
  output logic                   wb_done,
  output logic                   overrun_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             burst_len;
  logic [3:0]             wr_cnt;
  logic [12:0]            rd_cnt;
  logic [DRAM_ADDR_W-1:0] dram_ptr;

  // Two-entry FIFO. The word returning from out_mem (rd_in_flight) is treated
  // as the FIFO's entry-in-waiting: when the stored part is empty it is
  // presented directly as the head, which gives the 1-cycle read latency to
  // dram_wr_valid. fifo_count + rd_in_flight never exceeds 2.
  logic [DATA_W-1:0]      fifo_mem [2];
  logic                   fifo_wptr;
  logic                   fifo_rptr;
  logic [1:0]             fifo_count;
  logic                   rd_in_flight;

  logic                   wr_fire;
  logic                   pop_stored;
  logic                   push;

  assign out_mem_rd_addr = rd_cnt;
  assign en_out_mem_rd   = (state == FILL) &&
                           ((fifo_count + {1'b0, rd_in_flight}) < 2'd2);
  assign dram_wr_valid   = (fifo_count != 2'd0) || rd_in_flight;
  assign dram_wr_data    = (fifo_count != 2'd0) ? fifo_mem[fifo_rptr] :
                           (rd_in_flight ? out_mem_dout : '0);
  assign dram_wr_addr    = dram_ptr;
  assign busy            = (state != IDLE);

  assign wr_fire    = dram_wr_valid && dram_wr_ready;
  // A handshake with nothing stored consumes the returning word directly,
  // so that word is never written into the FIFO.
  assign pop_stored = wr_fire && (fifo_count != 2'd0);
  assign push       = rd_in_flight && !(wr_fire && (fifo_count == 2'd0));

  // FIFO storage and read-in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0]  <= '0;
      fifo_mem[1]  <= '0;
      fifo_wptr    <= 1'b0;
      fifo_rptr    <= 1'b0;
      fifo_count   <= 2'd0;
      rd_in_flight <= 1'b0;
    end else begin
      rd_in_flight <= en_out_mem_rd;
      if (push) begin
        fifo_mem[fifo_wptr] <= out_mem_dout;
        fifo_wptr           <= ~fifo_wptr;
      end
      if (pop_stored) begin
        fifo_rptr <= ~fifo_rptr;
      end
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_stored};
    end
  end

  // Burst control FSM, DRAM pointer and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      burst_len   <= 4'd0;
      rd_cnt      <= 13'd0;
      wr_cnt      <= 4'd0;
      dram_ptr    <= '0;
      wb_done     <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      wb_done <= 1'b0;

      if (wr_fire) begin
        dram_ptr <= dram_ptr + DRAM_ADDR_W'(ADDR_STRIDE);
        wr_cnt   <= wr_cnt + 4'd1;
      end

      // A ready pulse while busy is dropped, only flagged.
      if (out_buf_ready && (state != IDLE)) begin
        overrun_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (dram_base_load) begin
            dram_ptr <= dram_base_addr;
          end
          if (out_buf_ready) begin
            if (conv_or_fc == 2'b00 || conv_or_fc == 2'b01) begin
              state     <= FILL;
              burst_len <= (conv_or_fc == 2'b00) ? 4'(CONV_BURST) : 4'(FC_BURST);
              rd_cnt    <= 13'd0;
              wr_cnt    <= 4'd0;
            end else begin
              // Invalid layer type: acknowledge with wb_done, move no data.
              wb_done <= 1'b1;
            end
          end
        end

        FILL: begin
          if (en_out_mem_rd) begin
            rd_cnt <= rd_cnt + 13'd1;
            if ((rd_cnt + 13'd1) == {9'd0, burst_len}) begin
              state <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Leave on the final handshake so wb_done and !busy appear together
          // in the following cycle.
          if (wr_fire && ((wr_cnt + 4'd1) == burst_len)) begin
            state   <= IDLE;
            wb_done <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_mem_dram_writer.sv
// ---------------------------------------------------------------------------
// tb_out_mem_dram_writer
//
// Self-checking bench for out_mem_dram_writer. Expected DRAM writes come from
// a burst-level reference model (a queue of {addr, data} built from the
// out_mem contents and the running pointer) and are compared by a monitor.
// Per-burst results (latency, word count, end pointer, flags) come from a
// table of vectors, random bursts, and hand-written corner-case sequences.
// ---------------------------------------------------------------------------
module tb_out_mem_dram_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  conv_or_fc;
  logic        out_buf_ready;
  logic        dram_base_load;
  logic [31:0] dram_base_addr;
  logic [12:0] out_mem_rd_addr;
  logic        en_out_mem_rd;
  logic [31:0] out_mem_dout;
  logic        dram_wr_valid;
  logic [31:0] dram_wr_addr;
  logic [31:0] dram_wr_data;
  logic        dram_wr_ready;
  logic        busy;
  logic        wb_done;
  logic        overrun_err;

  out_mem_dram_writer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .conv_or_fc      (conv_or_fc),
    .out_buf_ready   (out_buf_ready),
    .dram_base_load  (dram_base_load),
    .dram_base_addr  (dram_base_addr),
    .out_mem_rd_addr (out_mem_rd_addr),
    .en_out_mem_rd   (en_out_mem_rd),
    .out_mem_dout    (out_mem_dout),
    .dram_wr_valid   (dram_wr_valid),
    .dram_wr_addr    (dram_wr_addr),
    .dram_wr_data    (dram_wr_data),
    .dram_wr_ready   (dram_wr_ready),
    .busy            (busy),
    .wb_done         (wb_done),
    .overrun_err     (overrun_err)
  );

  always #5 clk = ~clk;

  // out_mem: synchronous read, data returns the cycle after the enable.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (en_out_mem_rd) out_mem_dout <= mem[out_mem_rd_addr[3:0]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        load;
    logic [31:0] base;
    logic [1:0]  kind;
    int          rdy_mode;   // 0 always ready, 1 pattern 1,0,0 repeating, 2 random
    int          exp_words;
    logic [31:0] exp_end;    // dram_wr_addr once idle again
    int          exp_lat;    // cycle of wb_done after the pulse, -1 = not checked
    int          exp_first;  // cycle of first valid, -1 = not checked
    int          exp_busy;   // busy cycle count, -1 = not checked
    int          extra_n;    // cycle of a second out_buf_ready pulse, -1 = none
  } vec_t;

  wr_t         exp_q[$];
  logic [31:0] model_ptr;
  logic        overrun_exp;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int occ_rd   = 0;
  int occ_acc  = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [31:0] prev_data;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a burst writes its words to consecutive addresses from
  // the running pointer, which a load replaces beforehand.
  task automatic modelStart(input logic load, input logic [31:0] base,
                            input logic [1:0] kind);
    int len;
    if (load) model_ptr = base;
    if (kind < 2'd2) begin
      len = (kind == 2'b00) ? 7 : 1;
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{model_ptr, mem[i]});
        model_ptr += 32'd4;
      end
    end
  endtask

  function automatic logic readyFor(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n < 2) ? 1'b1 : (((n - 2) % 3) == 0);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  // Monitor: write ordering/content, stability under back-pressure and the
  // number of words read but not yet written (at most 2).
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      prev_stall = 1'b0;
      occ_rd     = 0;
      occ_acc    = 0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", {31'd0, dram_wr_valid}, 32'd1);
        checkOutput("hold_addr", dram_wr_addr, prev_addr);
        checkOutput("hold_data", dram_wr_data, prev_data);
      end
      checkOutput("occupancy_le_2", {31'd0, (occ_rd - occ_acc) <= 2}, 32'd1);
      if (dram_wr_valid && dram_wr_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL extra_write: got addr 0x%0h data 0x%0h, expected no write",
                   dram_wr_addr, dram_wr_data);
        end else begin
          checkOutput("wr_addr", dram_wr_addr, exp_q[0].addr);
          checkOutput("wr_data", dram_wr_data, exp_q[0].data);
          void'(exp_q.pop_front());
        end
        acc_cnt++;
        occ_acc++;
      end
      if (en_out_mem_rd) occ_rd++;
      prev_stall = dram_wr_valid && !dram_wr_ready;
      prev_addr  = dram_wr_addr;
      prev_data  = dram_wr_data;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_addr"}, {19'd0, out_mem_rd_addr}, 32'd0);
    checkOutput({tag, "_en_rd"}, {31'd0, en_out_mem_rd}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, dram_wr_valid}, 32'd0);
    checkOutput({tag, "_wr_addr"}, dram_wr_addr, 32'd0);
    checkOutput({tag, "_wr_data"}, dram_wr_data, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_wb_done"}, {31'd0, wb_done}, 32'd0);
    checkOutput({tag, "_overrun"}, {31'd0, overrun_err}, 32'd0);
  endtask

  // Runs one burst: pulse, then per-cycle ready drive and observation until
  // two cycles past wb_done (bounded), then the burst-level checks.
  task automatic applyStimulus(input vec_t v, input string tag);
    int n, first_n, wb_n, wb_cnt, busy_cnt, acc0;
    bit done;
    @(negedge clk);
    dram_base_load = v.load;
    dram_base_addr = v.base;
    conv_or_fc     = v.kind;
    out_buf_ready  = 1'b1;
    modelStart(v.load, v.base, v.kind);
    acc0 = acc_cnt;
    @(negedge clk);
    out_buf_ready  = 1'b0;
    dram_base_load = 1'b0;
    conv_or_fc     = v.kind ^ 2'b01;
    n = 1; first_n = -1; wb_n = -1; wb_cnt = 0; busy_cnt = 0; done = 0;
    while (!done) begin
      dram_wr_ready = readyFor(v.rdy_mode, n);
      out_buf_ready = (n == v.extra_n);
      if (n == v.extra_n) overrun_exp = 1'b1;
      #1;
      if (dram_wr_valid && first_n < 0) first_n = n;
      if (busy) busy_cnt++;
      if (wb_done) begin
        wb_cnt++;
        if (wb_n < 0) wb_n = n;
      end
      if ((wb_n >= 0 && n >= wb_n + 2) || n >= 200) done = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    dram_wr_ready = 1'b1;
    out_buf_ready = 1'b0;
    checkOutput({tag, "_wb_seen"}, {31'd0, wb_n >= 0}, 32'd1);
    checkOutput({tag, "_wb_count"}, wb_cnt, 32'd1);
    checkOutput({tag, "_words"}, acc_cnt - acc0, v.exp_words);
    checkOutput({tag, "_end_ptr"}, dram_wr_addr, v.exp_end);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    checkOutput({tag, "_overrun"}, {31'd0, overrun_err}, {31'd0, overrun_exp});
    if (v.exp_lat >= 0)   checkOutput({tag, "_wb_latency"}, wb_n, v.exp_lat);
    if (v.exp_first >= 0) checkOutput({tag, "_first_valid"}, first_n, v.exp_first);
    if (v.exp_busy >= 0)  checkOutput({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    if (v.exp_words == 0) checkOutput({tag, "_no_valid"}, first_n, 32'hFFFF_FFFF);
  endtask

  vec_t table_v [8];

  initial begin
    int n, wb_n, wb_cnt, acc0, len, busy_seen;
    vec_t rv;

    table_v[0] = '{1'b1, 32'h0000_1000, 2'b00, 0, 7, 32'h0000_101C, 9, 2, 8, -1};
    table_v[1] = '{1'b0, 32'h0,         2'b01, 0, 1, 32'h0000_1020, 3, 2, 2, -1};
    table_v[2] = '{1'b0, 32'h0,         2'b00, 1, 7, 32'h0000_103C, -1, 2, -1, -1};
    table_v[3] = '{1'b1, 32'hFFFF_FFFC, 2'b01, 0, 1, 32'h0000_0000, 3, 2, 2, -1};
    table_v[4] = '{1'b0, 32'h0,         2'b01, 0, 1, 32'h0000_0004, 3, 2, 2, -1};
    table_v[5] = '{1'b0, 32'h0,         2'b10, 0, 0, 32'h0000_0004, 1, -1, 0, -1};
    table_v[6] = '{1'b0, 32'h0,         2'b11, 0, 0, 32'h0000_0004, 1, -1, 0, -1};
    table_v[7] = '{1'b1, 32'h0000_2000, 2'b00, 2, 7, 32'h0000_201C, -1, 2, -1, -1};

    rst_n          = 1'b0;
    conv_or_fc     = 2'b00;
    out_buf_ready  = 1'b0;
    dram_base_load = 1'b0;
    dram_base_addr = 32'h0;
    dram_wr_ready  = 1'b1;
    model_ptr      = 32'h0;
    overrun_exp    = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hA0 + i;

    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(table_v[i], $sformatf("vec%0d", i));

    // A new pulse in the wb_done cycle starts the next burst, no overrun.
    @(negedge clk);
    conv_or_fc    = 2'b01;
    out_buf_ready = 1'b1;
    modelStart(1'b0, 32'h0, 2'b01);
    acc0 = acc_cnt;
    @(negedge clk);
    out_buf_ready = 1'b0;
    n = 1; wb_n = -1;
    while (wb_n < 0 && n < 50) begin
      #1;
      if (wb_done) wb_n = n;
      else begin
        @(negedge clk);
        n++;
      end
    end
    checkOutput("coinc_first_wb_latency", wb_n, 32'd3);
    out_buf_ready = 1'b1;
    modelStart(1'b0, 32'h0, 2'b01);
    @(negedge clk);
    out_buf_ready = 1'b0;
    #1;
    checkOutput("coinc_no_overrun", {31'd0, overrun_err}, 32'd0);
    checkOutput("coinc_busy_again", {31'd0, busy}, 32'd1);
    n = 0; wb_n = -1;
    while (wb_n < 0 && n < 50) begin
      if (wb_done) wb_n = n;
      else begin
        @(negedge clk);
        #1;
        n++;
      end
    end
    checkOutput("coinc_second_wb_seen", {31'd0, wb_n >= 0}, 32'd1);
    @(negedge clk);
    checkOutput("coinc_words", acc_cnt - acc0, 32'd2);
    checkOutput("coinc_end_ptr", dram_wr_addr, 32'h0000_2024);
    checkOutput("coinc_queue_empty", exp_q.size(), 32'd0);

    // Second pulse mid-burst: flagged, dropped, burst unaffected.
    rv = '{1'b1, 32'h0000_3000, 2'b00, 0, 7, 32'h0000_301C, 9, 2, 8, 4};
    applyStimulus(rv, "overrun");

    // Random bursts against the reference model; overrun_err stays sticky.
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 7; i++) mem[i] = $urandom;
      rv.kind     = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      rv.load     = ($urandom_range(0, 2) == 0);
      rv.base     = $urandom & 32'hFFFF_FFFC;
      rv.rdy_mode = $urandom_range(0, 2);
      rv.extra_n  = -1;
      len          = (rv.kind == 2'b00) ? 7 : ((rv.kind == 2'b01) ? 1 : 0);
      rv.exp_words = len;
      rv.exp_end   = (rv.load ? rv.base : model_ptr) + 32'(4 * len);
      rv.exp_first = (len > 0) ? 2 : -1;
      rv.exp_lat   = (len == 0) ? 1 : ((rv.rdy_mode == 0) ? len + 2 : -1);
      rv.exp_busy  = (len == 0) ? 0 : ((rv.rdy_mode == 0) ? len + 1 : -1);
      applyStimulus(rv, $sformatf("rand%0d", k));
    end

    // Reset while the 3rd word of a CONV burst is on the bus.
    for (int i = 0; i < 7; i++) mem[i] = 32'hC0 + i;
    @(negedge clk);
    conv_or_fc    = 2'b00;
    out_buf_ready = 1'b1;
    modelStart(1'b0, 32'h0, 2'b00);
    @(negedge clk);
    out_buf_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_third_valid", {31'd0, dram_wr_valid}, 32'd1);
    checkOutput("rst_third_data", dram_wr_data, 32'hC2);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    exp_q.delete();
    model_ptr   = 32'h0;
    overrun_exp = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    wb_cnt = 0; busy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (wb_done) wb_cnt++;
      if (busy || dram_wr_valid) busy_seen++;
    end
    checkOutput("postrst_no_wb_done", wb_cnt, 32'd0);
    checkOutput("postrst_idle", busy_seen, 32'd0);
    checkOutput("postrst_ptr", dram_wr_addr, 32'd0);
    checkOutput("postrst_overrun", {31'd0, overrun_err}, 32'd0);

    rv = '{1'b0, 32'h0, 2'b01, 0, 1, 32'h0000_0004, 3, 2, 2, -1};
    applyStimulus(rv, "postrst_fc");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
